reg8file_arbiter: RTL and testbench
===================================

Name: reg8file_arbiter

Overview:
- Sits between two clients (A, B) and the 8 x 8-bit register file (write port: en/wsel/d; read port: rsel/q).
- After reset it initialises all eight registers to INIT_VAL.
- It then shares the single write port and the single read port between A and B, using independent round-robin arbitration and a req/ack handshake.
- Read data returns registered, one cycle after the read grant.

Parameters:
- INIT_VAL, 8'h00: value written to registers 0..7 during the init sequence.
- BYPASS, 0: 1 = a read granted in the same cycle as a write to the same address returns the new write data; 0 = it returns the old register content.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  asynchronous, active-low reset.
- a_wreq, b_wreq  in  1  write request, held until ack.
- a_waddr, b_waddr  in  3  write register index.
- a_wdata, b_wdata  in  8  write data.
- a_wack, b_wack  out  1  write grant; the write commits at this clock edge.
- a_rreq, b_rreq  in  1  read request, held until ack.
- a_raddr, b_raddr  in  3  read register index.
- a_rack, b_rack  out  1  read grant.
- a_rvalid, b_rvalid  out  1  one-cycle pulse, registered; rdata is valid while it is high.
- a_rdata, b_rdata  out  8  registered read data, held until the next rvalid for that client.
- busy  out  1  high during reset wait and init.
- rf_en  out  1  register-file write enable.
- rf_wsel  out  3  register-file write select.
- rf_d  out  8  register-file write data.
- rf_rsel  out  3  register-file read select.
- rf_q  in  8  register-file read data, combinational from rf_rsel.

Behaviour:
- FSM states: RST_WAIT (reset state) -> INIT -> RUN.
  - RST_WAIT lasts exactly one cycle after clr rises.
  - INIT lasts 8 cycles; counter cnt counts 0..7; each cycle rf_en=1, rf_wsel=cnt, rf_d=INIT_VAL.
  - At cnt=7 the FSM moves to RUN.
  - RUN persists until reset.
- Reset values and forced outputs:
  - While clr=0: state=RST_WAIT, cnt=0, wprio=A, rprio=A, a_rvalid=b_rvalid=0, a_rdata=b_rdata=0.
  - rf_en=0 whenever state != INIT and no write grant is active.
  - busy=1 in RST_WAIT and INIT, 0 in RUN.
  - In RST_WAIT and INIT: all wack/rack=0 and requests are ignored (they stay pending).
- Write arbitration (RUN):
  - Combinational grant: single requester -> granted.
  - Both requesting -> client selected by wprio is granted.
  - Grant X: wack_X=1, rf_en=1, rf_wsel=X_waddr, rf_d=X_wdata; the register updates at that edge.
  - After any write grant, wprio points to the other client; with no grant, wprio is unchanged.
  - No request: rf_en=0, and rf_wsel/rf_d hold don't-care (drive 0).
- Read arbitration (RUN):
  - Same scheme with rprio, independent of the write arbiter.
  - Grant X: rack_X=1, rf_rsel=X_raddr.
  - At that edge X_rdata <= rf_q (or the bypass value), and X_rvalid=1 for the following cycle only.
  - With no read grant, rf_rsel=0.
- Back-to-back: a client holding req continuously is acked each cycle it wins; one transaction per ack. It must change addr/data in the cycle after ack, or drop req.
- Same-cycle read and write to the same address:
  - BYPASS=0: rdata = old register value.
  - BYPASS=1: rdata = written data.
  - Different addresses: no interaction.
- Concurrency: a write and a read may be granted to the same or to different clients in the same cycle.
- Reset mid-operation: clr low at any time aborts init or pending transfers. Clearing is immediate: rvalid=0, acks=0 combinationally via state, and the full sequence restarts from RST_WAIT. Requesters must reissue after busy falls.
- No width arithmetic beyond the 3-bit cnt; cnt does not wrap in use because the FSM leaves INIT at 7.

Test Plan:
- Reset then release with INIT_VAL=8'h5A: busy=1 for 9 cycles, rf_en=1 with rf_wsel=0..7 on cycles 2-9, busy=0 after. Subsequent read of reg 3 by A returns 8'h5A, with a_rvalid one cycle after a_rack.
- A writes 8'h03 to reg 1 alone: a_wack high in the same cycle. Then A reads reg 1: a_rdata=8'h03.
- A and B both hold wreq for 4 cycles (A: reg 2 8'h11, B: reg 5 8'h22, each then new data): grants alternate A,B,A,B. wprio ends at A.
- Simultaneous A write reg 3 = 8'h83 and B read reg 3: BYPASS=0 gives b_rdata=8'h5A; BYPASS=1 gives 8'h83.
- Both read different regs in the same cycle with rprio=A: A acked first and B acked the next cycle. Rvalids pulse in consecutive cycles with the correct data.
- Pull clr low during INIT at cnt=4 with a_wreq pending: acks stay 0 and rvalid=0. After release the sequence restarts at cnt=0, and A's write is acked only after busy falls.

Source files
------------

// File: rtl/reg8file_arbiter.sv
// Two-client round-robin front end for an 8x8 register file; sequences INIT_VAL into all registers after reset.
// Write/read acks are combinational same-cycle grants; read data returns one cycle after rack; losers hold req.
module reg8file_arbiter #(
    parameter logic [7:0] INIT_VAL = 8'h00,
    parameter bit         BYPASS   = 1'b0
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       a_wreq,
    input  logic [2:0] a_waddr,
    input  logic [7:0] a_wdata,
    output logic       a_wack,
    input  logic       b_wreq,
    input  logic [2:0] b_waddr,
    input  logic [7:0] b_wdata,
    output logic       b_wack,
    input  logic       a_rreq,
    input  logic [2:0] a_raddr,
    output logic       a_rack,
    output logic       a_rvalid,
    output logic [7:0] a_rdata,
    input  logic       b_rreq,
    input  logic [2:0] b_raddr,
    output logic       b_rack,
    output logic       b_rvalid,
    output logic [7:0] b_rdata,
    output logic       busy,
    output logic       rf_en,
    output logic [2:0] rf_wsel,
    output logic [7:0] rf_d,
    output logic [2:0] rf_rsel,
    input  logic [7:0] rf_q
);

    typedef enum logic [1:0] {
        RST_WAIT = 2'd0,
        INIT     = 2'd1,
        RUN      = 2'd2
    } state_t;

    typedef struct packed {
        logic       en;
        logic [2:0] sel;
        logic [7:0] dat;
    } wr_t;

    state_t     state, state_nxt;
    logic [2:0] cnt, cnt_nxt;
    logic       wprio, rprio;     // 0 = A has priority, 1 = B
    logic       run;
    wr_t        wr;
    logic [7:0] rd_val;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= RST_WAIT;
            cnt   <= 3'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            RST_WAIT: state_nxt = INIT;
            INIT: begin
                if (cnt == 3'd7) begin
                    state_nxt = RUN;
                    cnt_nxt   = 3'd0;
                end else begin
                    cnt_nxt = cnt + 3'd1;
                end
            end
            RUN:     state_nxt = RUN;
            default: state_nxt = RST_WAIT;
        endcase
    end

    assign run  = (state == RUN);
    assign busy = !run;

    // Ties go to the prioritised client; a lone requester always wins.
    assign a_wack = run && a_wreq && (!b_wreq || !wprio);
    assign b_wack = run && b_wreq && (!a_wreq ||  wprio);
    assign a_rack = run && a_rreq && (!b_rreq || !rprio);
    assign b_rack = run && b_rreq && (!a_rreq ||  rprio);

    always_comb begin
        wr = '0;
        if (state == INIT) begin
            wr.en  = 1'b1;
            wr.sel = cnt;
            wr.dat = INIT_VAL;
        end else if (a_wack) begin
            wr.en  = 1'b1;
            wr.sel = a_waddr;
            wr.dat = a_wdata;
        end else if (b_wack) begin
            wr.en  = 1'b1;
            wr.sel = b_waddr;
            wr.dat = b_wdata;
        end
    end

    assign rf_en   = wr.en;
    assign rf_wsel = wr.sel;
    assign rf_d    = wr.dat;

    always_comb begin
        rf_rsel = 3'd0;
        if (a_rack)
            rf_rsel = a_raddr;
        else if (b_rack)
            rf_rsel = b_raddr;
    end

    // A same-cycle write to the read address is only forwarded when BYPASS is set.
    always_comb begin
        rd_val = rf_q;
        if (BYPASS && run && wr.en && (wr.sel == rf_rsel))
            rd_val = wr.dat;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            wprio <= 1'b0;
            rprio <= 1'b0;
        end else begin
            if (a_wack)
                wprio <= 1'b1;
            else if (b_wack)
                wprio <= 1'b0;
            if (a_rack)
                rprio <= 1'b1;
            else if (b_rack)
                rprio <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            a_rdata  <= 8'h00;
            b_rdata  <= 8'h00;
        end else begin
            a_rvalid <= a_rack;
            b_rvalid <= b_rack;
            if (a_rack)
                a_rdata <= rd_val;
            if (b_rack)
                b_rdata <= rd_val;
        end
    end

endmodule

// File: tb/tb_reg8file_arbiter.sv
// Randomised scoreboard bench: two DUT copies (BYPASS=0/1) share stimulus, each with its own register file.
module tb_reg8file_arbiter;

    localparam logic [7:0] IV = 8'h5A;
    localparam int NCYC = 3000;

    logic clk = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    logic       a_wreq = 1'b0, b_wreq = 1'b0, a_rreq = 1'b0, b_rreq = 1'b0;
    logic [2:0] a_waddr = '0, b_waddr = '0, a_raddr = '0, b_raddr = '0;
    logic [7:0] a_wdata = '0, b_wdata = '0;

    logic [1:0]       a_wack, b_wack, a_rack, b_rack, a_rvalid, b_rvalid, busy, rf_en;
    logic [1:0][7:0]  a_rdata, b_rdata, rf_d, rf_q;
    logic [1:0][2:0]  rf_wsel, rf_rsel;

    logic [7:0] rf_m0 [8];
    logic [7:0] rf_m1 [8];

    always @(posedge clk) begin
        if (rf_en[0]) rf_m0[rf_wsel[0]] <= rf_d[0];
        if (rf_en[1]) rf_m1[rf_wsel[1]] <= rf_d[1];
    end
    assign rf_q[0] = rf_m0[rf_rsel[0]];
    assign rf_q[1] = rf_m1[rf_rsel[1]];

    reg8file_arbiter #(.INIT_VAL(IV), .BYPASS(1'b0)) u_dut0 (
        .clk(clk), .clr(clr),
        .a_wreq(a_wreq), .a_waddr(a_waddr), .a_wdata(a_wdata), .a_wack(a_wack[0]),
        .b_wreq(b_wreq), .b_waddr(b_waddr), .b_wdata(b_wdata), .b_wack(b_wack[0]),
        .a_rreq(a_rreq), .a_raddr(a_raddr), .a_rack(a_rack[0]), .a_rvalid(a_rvalid[0]), .a_rdata(a_rdata[0]),
        .b_rreq(b_rreq), .b_raddr(b_raddr), .b_rack(b_rack[0]), .b_rvalid(b_rvalid[0]), .b_rdata(b_rdata[0]),
        .busy(busy[0]), .rf_en(rf_en[0]), .rf_wsel(rf_wsel[0]), .rf_d(rf_d[0]),
        .rf_rsel(rf_rsel[0]), .rf_q(rf_q[0])
    );

    reg8file_arbiter #(.INIT_VAL(IV), .BYPASS(1'b1)) u_dut1 (
        .clk(clk), .clr(clr),
        .a_wreq(a_wreq), .a_waddr(a_waddr), .a_wdata(a_wdata), .a_wack(a_wack[1]),
        .b_wreq(b_wreq), .b_waddr(b_waddr), .b_wdata(b_wdata), .b_wack(b_wack[1]),
        .a_rreq(a_rreq), .a_raddr(a_raddr), .a_rack(a_rack[1]), .a_rvalid(a_rvalid[1]), .a_rdata(a_rdata[1]),
        .b_rreq(b_rreq), .b_raddr(b_raddr), .b_rack(b_rack[1]), .b_rvalid(b_rvalid[1]), .b_rdata(b_rdata[1]),
        .busy(busy[1]), .rf_en(rf_en[1]), .rf_wsel(rf_wsel[1]), .rf_d(rf_d[1]),
        .rf_rsel(rf_rsel[1]), .rf_q(rf_q[1])
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%h expected=%h", nm, $time, act, exp);
        end
    endtask

    // Reference model state: cycles since reset release, arbiter priorities, register contents.
    int         k = 0;
    logic       mw = 1'b0, mr = 1'b0;
    logic [7:0] mem [8];
    logic [7:0] expq [4][$];   // channel = instance*2 + client (A=0, B=1)
    logic [7:0] last_rd [4];

    // Read-data monitor: a rack in cycle t must produce exactly one rvalid in cycle t+1.
    initial begin
        logic [3:0]      rv;
        logic [3:0][7:0] rd;
        logic [7:0]      e;
        for (int c = 0; c < 4; c++) last_rd[c] = 8'h00;
        forever begin
            @(posedge clk);
            #2;
            rv = {b_rvalid[1], a_rvalid[1], b_rvalid[0], a_rvalid[0]};
            rd = {b_rdata[1], a_rdata[1], b_rdata[0], a_rdata[0]};
            for (int c = 0; c < 4; c++) begin
                if (!clr) begin
                    chk($sformatf("rst_rvalid%0d", c), 8'(rv[c]), 8'h00);
                    chk($sformatf("rst_rdata%0d", c), rd[c], 8'h00);
                    last_rd[c] = 8'h00;
                end else if (rv[c]) begin
                    chk($sformatf("rvalid_expected%0d", c), 8'(expq[c].size() > 0), 8'h01);
                    if (expq[c].size() > 0) begin
                        e = expq[c].pop_front();
                        chk($sformatf("rdata%0d", c), rd[c], e);
                        last_rd[c] = e;
                    end
                end else begin
                    chk($sformatf("rdata_hold%0d", c), rd[c], last_rd[c]);
                    chk($sformatf("rvalid_missing%0d", c), 8'(expq[c].size()), 8'h00);
                    expq[c].delete();
                end
            end
        end
    end

    initial begin
        int   rst_left;
        bit   aborted;
        bit   quiet;
        logic wa_done, wb_done, ra_done, rb_done;
        logic run, ewa, ewb, era, erb, e_en;
        logic [2:0] e_ws, e_rs;
        logic [7:0] e_d, old_v, new_v;

        rst_left = 3;
        aborted  = 1'b0;
        wa_done = 1'b0; wb_done = 1'b0; ra_done = 1'b0; rb_done = 1'b0;
        for (int i = 0; i < 8; i++) mem[i] = IV;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            #1;
            quiet = (cyc >= NCYC - 20);
            if (rst_left > 0) begin
                clr = 1'b0;
                rst_left--;
            end else if (!aborted && clr && k == 5) begin
                clr      = 1'b0;   // abort init at cnt=4 with requests pending
                rst_left = 1;
                aborted  = 1'b1;
            end else if (!quiet && cyc > 60 && $urandom_range(0, 249) == 0) begin
                clr      = 1'b0;
                rst_left = $urandom_range(0, 2);
            end else begin
                clr = 1'b1;
            end
            if (!clr)
                for (int c = 0; c < 4; c++) expq[c].delete();

            if (wa_done || !a_wreq) begin
                a_wreq  = !quiet && ($urandom_range(0, 9) < 7);
                a_waddr = 3'($urandom);
                a_wdata = 8'($urandom);
            end
            if (wb_done || !b_wreq) begin
                b_wreq  = !quiet && ($urandom_range(0, 9) < 7);
                b_waddr = 3'($urandom);
                b_wdata = 8'($urandom);
            end
            if (ra_done || !a_rreq) begin
                a_rreq  = !quiet && ($urandom_range(0, 9) < 7);
                a_raddr = 3'($urandom);
            end
            if (rb_done || !b_rreq) begin
                b_rreq  = !quiet && ($urandom_range(0, 9) < 7);
                b_raddr = 3'($urandom);
            end

            @(negedge clk);
            run = clr && (k >= 9);
            ewa = run && a_wreq && (!b_wreq || mw == 1'b0);
            ewb = run && b_wreq && (!a_wreq || mw == 1'b1);
            era = run && a_rreq && (!b_rreq || mr == 1'b0);
            erb = run && b_rreq && (!a_rreq || mr == 1'b1);

            e_en = 1'b0; e_ws = 3'd0; e_d = 8'h00;
            if (clr && k >= 1 && k <= 8) begin
                e_en = 1'b1; e_ws = 3'(k - 1); e_d = IV;
            end else if (ewa) begin
                e_en = 1'b1; e_ws = a_waddr; e_d = a_wdata;
            end else if (ewb) begin
                e_en = 1'b1; e_ws = b_waddr; e_d = b_wdata;
            end
            e_rs = era ? a_raddr : (erb ? b_raddr : 3'd0);

            for (int i = 0; i < 2; i++) begin
                chk("a_wack", 8'(a_wack[i]), 8'(ewa));
                chk("b_wack", 8'(b_wack[i]), 8'(ewb));
                chk("a_rack", 8'(a_rack[i]), 8'(era));
                chk("b_rack", 8'(b_rack[i]), 8'(erb));
                chk("busy", 8'(busy[i]), 8'(!run));
                chk("rf_en", 8'(rf_en[i]), 8'(e_en));
                if (e_en) begin
                    chk("rf_wsel", 8'(rf_wsel[i]), 8'(e_ws));
                    chk("rf_d", rf_d[i], e_d);
                end
                chk("rf_rsel", 8'(rf_rsel[i]), 8'(e_rs));
            end

            if (era || erb) begin
                old_v = mem[e_rs];
                new_v = (run && e_en && e_ws == e_rs) ? e_d : old_v;
                expq[era ? 0 : 1].push_back(old_v);
                expq[era ? 2 : 3].push_back(new_v);
            end

            if (ewa) mem[a_waddr] = a_wdata;
            if (ewb) mem[b_waddr] = b_wdata;
            if (ewa || ewb) mw = ewa;
            if (era || erb) mr = era;

            if (!clr) begin
                k  = 0;
                mw = 1'b0;
                mr = 1'b0;
                for (int i = 0; i < 8; i++) mem[i] = IV;
            end else if (k < 20) begin
                k++;
            end
            wa_done = ewa; wb_done = ewb; ra_done = era; rb_done = erb;
        end

        repeat (3) @(posedge clk);
        #3;
        for (int c = 0; c < 4; c++)
            chk($sformatf("drain%0d", c), 8'(expq[c].size()), 8'h00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
